cpu_clock_controller: RTL and testbench

Run/halt/step/burst sequencer for the CPU core clock. Produces a single-cycle clock-enable pulse, cpu_en, from the board clock through a programmable prescaler. Replaces free-running divided clocks: the CPU datapath stays on the board clock and advances only when cpu_en is high. Driven by debug buttons and switches for single-stepping, bounded bursts and free run.

---
 rtl/clkctl_pkg.sv | 11 +
 rtl/clk_prescaler.sv | 36 +++
 rtl/cpu_clock_controller.sv | 118 +++++++++++
 tb/tb_cpu_clock_controller.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clkctl_pkg.sv
// Shared state encodings for the CPU clock-enable sequencer.
package clkctl_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_HALT  = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
  localparam logic [STATE_W-1:0] ST_STEP  = 2'd2;
  localparam logic [STATE_W-1:0] ST_BURST = 2'd3;

endpackage

// File: rtl/clk_prescaler.sv
// Programmable prescaler: counts 0..divisor and flags a tick on the terminal count.
module clk_prescaler #(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic                 i_load,
  input  logic [DIV_WIDTH-1:0] i_div_in,
  output logic                 o_tick_c
);

  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_count;

  // A held clear (idle) suppresses the tick even though count==div may hold.
  assign o_tick_c = !i_clear && (r_count == r_div);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_div   <= DIV_WIDTH'(DEFAULT_DIV);
      r_count <= '0;
    end else begin
      if (i_load) begin
        r_div <= i_div_in;
      end
      if (i_load || i_clear || o_tick_c) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_clock_controller.sv
// Run/halt/step/burst sequencer producing a one-cycle CPU clock-enable pulse.
// Macro CLKCTL_CYCLE_COUNT_EN builds the retired-enable counter; otherwise cycle_count is 0.
module cpu_clock_controller
  import clkctl_pkg::*;
#(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 2,
  parameter int unsigned BURST_WIDTH = 8,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run_req,
  input  logic                   halt_req,
  input  logic                   step_req,
  input  logic                   burst_req,
  input  logic [BURST_WIDTH-1:0] burst_len,
  input  logic                   div_load,
  input  logic [DIV_WIDTH-1:0]   div_in,
  output logic                   cpu_en,
  output logic [STATE_W-1:0]     state,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   cycle_count
);

  logic [STATE_W-1:0]     r_state;
  logic                   r_cpu_en;
  logic                   r_busy;
  logic [BURST_WIDTH-1:0] r_remaining;

  logic [STATE_W-1:0]     w_state_nxt;
  logic                   w_en_nxt;
  logic [BURST_WIDTH-1:0] w_rem_nxt;
  logic                   w_tick;
  logic                   w_idle;

  assign w_idle = (r_state == ST_HALT);

  clk_prescaler #(
    .DIV_WIDTH   (DIV_WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_prescaler (
    .i_clk    (clock),
    .i_rst_n  (reset),
    .i_clear  (w_idle),
    .i_load   (div_load),
    .i_div_in (div_in),
    .o_tick_c (w_tick)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= ST_HALT;
      r_cpu_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cpu_en    <= w_en_nxt;
      r_busy      <= (w_state_nxt != ST_HALT);
      r_remaining <= w_rem_nxt;
    end
  end

  // Commands are only decoded in HALT; halt_req pre-empts any tick in active states.
  always_comb begin
    w_state_nxt = r_state;
    w_en_nxt    = 1'b0;
    w_rem_nxt   = r_remaining;
    if (r_state == ST_HALT) begin
      if (!halt_req) begin
        if (run_req) begin
          w_state_nxt = ST_RUN;
        end else if (burst_req) begin
          if (burst_len != '0) begin
            w_state_nxt = ST_BURST;
            w_rem_nxt   = burst_len;
          end
        end else if (step_req) begin
          w_state_nxt = ST_STEP;
        end
      end
    end else if (halt_req) begin
      w_state_nxt = ST_HALT;
    end else if (w_tick) begin
      w_en_nxt = 1'b1;
      if (r_state == ST_STEP) begin
        w_state_nxt = ST_HALT;
      end else if (r_state == ST_BURST) begin
        w_rem_nxt = r_remaining - BURST_WIDTH'(1);
        if (r_remaining == BURST_WIDTH'(1)) begin
          w_state_nxt = ST_HALT;
        end
      end
    end
  end

`ifdef CLKCTL_CYCLE_COUNT_EN
  logic [CNT_WIDTH-1:0] r_cycle_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cycle_count <= '0;
    end else if (r_cpu_en) begin
      r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
    end
  end

  assign cycle_count = r_cycle_count;
`else
  assign cycle_count = CNT_WIDTH'(0);
`endif

  assign cpu_en = r_cpu_en;
  assign state  = r_state;
  assign busy   = r_busy;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Self-checking bench for cpu_clock_controller; honours CLKCTL_CYCLE_COUNT_EN if defined.
module tb_cpu_clock_controller;

  localparam int unsigned DIV_WIDTH   = 16;
  localparam int unsigned BURST_WIDTH = 8;
  localparam int unsigned CNT_WIDTH   = 32;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic                   run_req = 1'b0;
  logic                   halt_req = 1'b0;
  logic                   step_req = 1'b0;
  logic                   burst_req = 1'b0;
  logic [BURST_WIDTH-1:0] burst_len = '0;
  logic                   div_load = 1'b0;
  logic [DIV_WIDTH-1:0]   div_in = '0;
  logic                   cpu_en;
  logic [1:0]             state;
  logic                   busy;
  logic [CNT_WIDTH-1:0]   cycle_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  cpu_clock_controller dut (
    .clock       (clock),
    .reset       (reset),
    .run_req     (run_req),
    .halt_req    (halt_req),
    .step_req    (step_req),
    .burst_req   (burst_req),
    .burst_len   (burst_len),
    .div_load    (div_load),
    .div_in      (div_in),
    .cpu_en      (cpu_en),
    .state       (state),
    .busy        (busy),
    .cycle_count (cycle_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_cnt(input int n);
`ifdef CLKCTL_CYCLE_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  // Model: mode 0..3, countdown of edges until the next enable pulse.
  int          m_mode;
  int          m_div;
  int          m_left;
  int          m_rem;
  logic        m_en;
  logic        m_nen;
  logic [31:0] m_cnt;
  logic        m_valid = 1'b0;

  always @(posedge clock) begin
    if (!reset) begin
      m_mode = 0; m_div = 2; m_left = 0; m_rem = 0; m_en = 1'b0; m_cnt = '0;
    end else begin
`ifdef CLKCTL_CYCLE_COUNT_EN
      if (m_en) m_cnt = m_cnt + 32'd1;
`endif
      m_nen = 1'b0;
      if (m_mode == 0) begin
        if (!halt_req) begin
          if (run_req) begin
            m_mode = 1; m_left = m_div + 1;
          end else if (burst_req) begin
            if (burst_len != 0) begin
              m_mode = 3; m_rem = int'(burst_len); m_left = m_div + 1;
            end
          end else if (step_req) begin
            m_mode = 2; m_left = m_div + 1;
          end
        end
      end else if (halt_req) begin
        m_mode = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_nen  = 1'b1;
          m_left = m_div + 1;
          if (m_mode == 2) m_mode = 0;
          else if (m_mode == 3) begin
            m_rem--;
            if (m_rem == 0) m_mode = 0;
          end
        end
      end
      if (div_load) begin
        m_div  = int'(div_in);
        m_left = m_div + 1;
      end
      m_en = m_nen;
    end
    m_valid = 1'b1;
  end

  always @(negedge clock) begin
    if (m_valid) begin
      chk("cpu_en", 64'(cpu_en), 64'(m_en));
      chk("state", 64'(state), 64'(m_mode));
      chk("busy", 64'(busy), 64'(m_mode != 0));
      chk("cycle_count", 64'(cycle_count), 64'(m_cnt));
    end
  end

  int t0;
  int np;
  int pos[8];
  bit seen;

  // Observe pulses for n cycles; offsets are relative to t0.
  task automatic watch(input int n);
    np = 0;
    for (int i = 0; i < n; i++) begin
      if (cpu_en === 1'b1) begin
        if (np < 8) pos[np] = cyc - t0;
        np++;
      end
      @(negedge clock);
    end
  endtask

  task automatic load_div(input int d);
    div_load = 1'b1; div_in = DIV_WIDTH'(d);
    @(negedge clock);
    div_load = 1'b0;
  endtask

  initial begin
    reset = 1'b0; run_req = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_cpu_en", 64'(cpu_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(cycle_count), 64'd0);
    reset = 1'b1; run_req = 1'b0;
    @(negedge clock);

    // RUN with default divisor
    run_req = 1'b1; t0 = cyc;
    @(negedge clock);
    run_req = 1'b0;
    chk("run_busy", 64'(busy), 64'd1);
    watch(12);
    chk("run_npulse", 64'(np), 64'd3);
    chk("run_pos0", 64'(pos[0]), 64'd4);
    chk("run_pos1", 64'(pos[1]), 64'd7);
    chk("run_pos2", 64'(pos[2]), 64'd10);
    halt_req = 1'b1;
    @(negedge clock);
    halt_req = 1'b0;
    chk("run_halted", 64'(state), 64'd0);

    // STEP with divisor 0
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    load_div(0);
    for (int s = 0; s < 2; s++) begin
      step_req = 1'b1; t0 = cyc;
      @(negedge clock);
      step_req = 1'b0;
      watch(6);
      chk("step_npulse", 64'(np), 64'd1);
      chk("step_pos", 64'(pos[0]), 64'd2);
      chk("step_state", 64'(state), 64'd0);
    end
    chk("step_count", 64'(cycle_count), 64'(exp_cnt(2)));

    // BURST of 5 with divisor 1, then an ignored zero-length burst
    load_div(1);
    burst_req = 1'b1; burst_len = 8'd5; t0 = cyc;
    @(negedge clock);
    burst_req = 1'b0;
    watch(16);
    chk("burst_npulse", 64'(np), 64'd5);
    chk("burst_first", 64'(pos[0]), 64'd3);
    chk("burst_space", 64'(pos[1] - pos[0]), 64'd2);
    chk("burst_span", 64'(pos[4] - pos[0]), 64'd8);
    chk("burst_state", 64'(state), 64'd0);
    burst_req = 1'b1; burst_len = 8'd0;
    @(negedge clock);
    burst_req = 1'b0;
    watch(5);
    chk("burst0_npulse", 64'(np), 64'd0);
    chk("burst0_busy", 64'(busy), 64'd0);

    // RUN with divisor 3, halt on a tick cycle
    load_div(3);
    run_req = 1'b1; t0 = cyc;
    @(negedge clock);
    run_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (cpu_en === 1'b1) seen = 1'b1;
      else @(negedge clock);
    end
    chk("d3_first_seen", 64'(seen), 64'd1);
    chk("d3_first_pos", 64'(cyc - t0), 64'd5);
    repeat (3) @(negedge clock);
    halt_req = 1'b1;
    @(negedge clock);
    halt_req = 1'b0;
    chk("halt_tick_en", 64'(cpu_en), 64'd0);
    chk("halt_tick_state", 64'(state), 64'd0);

    // RUN, then divisor 0 mid-period
    run_req = 1'b1;
    @(negedge clock);
    run_req = 1'b0;
    repeat (2) @(negedge clock);
    load_div(0);
    @(negedge clock);
    t0 = cyc;
    watch(5);
    chk("div0_npulse", 64'(np), 64'd5);
    halt_req = 1'b1;
    @(negedge clock);
    halt_req = 1'b0;

    // Reset mid-burst
    burst_req = 1'b1; burst_len = 8'd20;
    @(negedge clock);
    burst_req = 1'b0;
    repeat (4) @(negedge clock);
    chk("mid_burst_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    @(negedge clock);
    chk("mb_rst_state", 64'(state), 64'd0);
    chk("mb_rst_en", 64'(cpu_en), 64'd0);
    chk("mb_rst_busy", 64'(busy), 64'd0);
    chk("mb_rst_count", 64'(cycle_count), 64'd0);
    reset = 1'b1;
    watch(6);
    chk("post_rst_npulse", 64'(np), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
